// File: rtl/lcd_hd44780_resp.sv
// HD44780-compatible LCD module responder: DDRAM, address counter, display flags and busy flag.
// Optional 4-bit bus operation (two nibble strobes per transfer) is enabled with `define LCD_4BIT_EN.
module lcd_hd44780_resp #(
    parameter int BUSY_CYC    = 37,
    parameter int CLEAR_CYC   = 1520,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       busy,
    output logic       busy_err,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_char
);

    localparam int SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CNT_MAX = (CLEAR_CYC > BUSY_CYC) ? CLEAR_CYC : BUSY_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LOAD_SHORT = CNT_W'(BUSY_CYC);
    localparam logic [CNT_W-1:0] LOAD_LONG  = CNT_W'(CLEAR_CYC);

    // Only 0x00-0x27 and 0x40-0x67 exist as DDRAM on a two-line module.
    function automatic logic addr_valid(input logic [6:0] a);
        return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    function automatic logic [6:0] ddram_idx(input logic [6:0] a);
        return a[6] ? (7'd40 + {1'b0, a[5:0]}) : {1'b0, a[5:0]};
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            case (a)
                7'h27:   r = 7'h40;
                7'h67:   r = 7'h00;
                default: r = a + 7'd1;
            endcase
        end else begin
            case (a)
                7'h40:   r = 7'h27;
                7'h00:   r = 7'h67;
                default: r = a - 7'd1;
            endcase
        end
        return r;
    endfunction

    logic [10:0]      sync_r [SYNC_N];
    logic             en_prev_r;
    logic             rs_s, rw_s, en_s, en_fall_s;
    logic [7:0]       data_s;
    logic [7:0]       ddram_r [80];
    logic [6:0]       ac_r, ac_nx_s;
    logic             id_r, id_nx_s, sh_r, sh_nx_s;
    logic             disp_r, disp_nx_s, cur_r, cur_nx_s, blink_r, blink_nx_s;
    logic             dl_r, dl_nx_s, n_r, n_nx_s;
    logic [CNT_W-1:0] cnt_r, load_val_s;
    logic             busy_r, busy_err_r, load_s;
    logic             phase_hi_r, nib_mode_s, xfer_s, nib_adv_s;
    logic [3:0]       nib_r;
    logic [7:0]       byte_s, rd_word_s, rd_byte_s, out_r;
    logic             oe_r, drop_s, wr_do_s, rd_do_s, clr_s, wr_mem_s;

`ifdef LCD_4BIT_EN
    assign nib_mode_s = ~dl_r;
`else
    assign nib_mode_s = 1'b0;
`endif

    // Bus synchroniser; rs/rw/data travel with en so they are stable at the falling edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_N; i++) sync_r[i] <= 11'd0;
            en_prev_r <= 1'b0;
        end else begin
            sync_r[0] <= {lcd_rs, lcd_rw, lcd_en, lcd_data_in};
            for (int i = 1; i < SYNC_N; i++) sync_r[i] <= sync_r[i-1];
            en_prev_r <= en_s;
        end
    end

    assign {rs_s, rw_s, en_s, data_s} = sync_r[SYNC_N-1];
    assign en_fall_s = en_prev_r & ~en_s;

    // Transfer qualification: nibble assembly, busy drop and completion strobes.
    always_comb begin
        byte_s    = nib_mode_s ? {nib_r, data_s[7:4]} : data_s;
        xfer_s    = ~nib_mode_s | ~phase_hi_r;
        drop_s    = en_fall_s & ~rw_s & busy_r;
        wr_do_s   = en_fall_s & ~rw_s & ~busy_r & xfer_s;
        rd_do_s   = en_fall_s & rw_s & xfer_s;
        nib_adv_s = en_fall_s & nib_mode_s & ~drop_s;
    end

    // Instruction / data decode producing next register state and busy load.
    always_comb begin
        ac_nx_s    = ac_r;
        id_nx_s    = id_r;
        sh_nx_s    = sh_r;
        disp_nx_s  = disp_r;
        cur_nx_s   = cur_r;
        blink_nx_s = blink_r;
        dl_nx_s    = dl_r;
        n_nx_s     = n_r;
        clr_s      = 1'b0;
        wr_mem_s   = 1'b0;
        load_s     = 1'b0;
        load_val_s = LOAD_SHORT;
        if (wr_do_s) begin
            if (rs_s) begin
                wr_mem_s = 1'b1;
                ac_nx_s  = ac_step(ac_r, id_r);
                load_s   = 1'b1;
            end else if (byte_s[7]) begin
                if (addr_valid(byte_s[6:0])) begin
                    ac_nx_s = byte_s[6:0];
                end else begin
                    ac_nx_s = ac_r;
                end
                load_s = 1'b1;
            end else if (byte_s[6]) begin
                load_s = 1'b1;
            end else if (byte_s[5]) begin
                dl_nx_s = byte_s[4];
                n_nx_s  = byte_s[3];
                load_s  = 1'b1;
            end else if (byte_s[4]) begin
                if (!byte_s[3]) begin
                    ac_nx_s = ac_step(ac_r, byte_s[2]);
                end else begin
                    ac_nx_s = ac_r;
                end
                load_s = 1'b1;
            end else if (byte_s[3]) begin
                disp_nx_s  = byte_s[2];
                cur_nx_s   = byte_s[1];
                blink_nx_s = byte_s[0];
                load_s     = 1'b1;
            end else if (byte_s[2]) begin
                id_nx_s = byte_s[1];
                sh_nx_s = byte_s[0];
                load_s  = 1'b1;
            end else if (byte_s[1]) begin
                ac_nx_s    = 7'h00;
                load_s     = 1'b1;
                load_val_s = LOAD_LONG;
            end else if (byte_s[0]) begin
                clr_s      = 1'b1;
                ac_nx_s    = 7'h00;
                id_nx_s    = 1'b1;
                load_s     = 1'b1;
                load_val_s = LOAD_LONG;
            end else begin
                load_s = 1'b0;
            end
        end else if (rd_do_s && rs_s) begin
            ac_nx_s = ac_step(ac_r, id_r);
        end else begin
            ac_nx_s = ac_r;
        end
    end

    // Address counter and mode flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ac_r    <= 7'h00;
            id_r    <= 1'b1;
            sh_r    <= 1'b0;
            disp_r  <= 1'b0;
            cur_r   <= 1'b0;
            blink_r <= 1'b0;
            dl_r    <= 1'b1;
            n_r     <= 1'b0;
        end else begin
            ac_r    <= ac_nx_s;
            id_r    <= id_nx_s;
            sh_r    <= sh_nx_s;
            disp_r  <= disp_nx_s;
            cur_r   <= cur_nx_s;
            blink_r <= blink_nx_s;
            dl_r    <= dl_nx_s;
            n_r     <= n_nx_s;
        end
    end

    // Nibble phase: a bus-width change always restarts on the high nibble.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_hi_r <= 1'b1;
            nib_r      <= 4'h0;
        end else if (dl_nx_s != dl_r) begin
            phase_hi_r <= 1'b1;
        end else if (nib_adv_s) begin
            phase_hi_r <= ~phase_hi_r;
            if (phase_hi_r) nib_r <= data_s[7:4];
        end
    end

    // DDRAM storage; clear fills every cell with a space.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 80; i++) ddram_r[i] <= 8'h20;
        end else if (clr_s) begin
            for (int i = 0; i < 80; i++) ddram_r[i] <= 8'h20;
        end else if (wr_mem_s) begin
            ddram_r[ddram_idx(ac_r)] <= byte_s;
        end
    end

    // Busy countdown: busy is high for exactly the loaded number of cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r      <= '0;
            busy_r     <= 1'b0;
            busy_err_r <= 1'b0;
        end else begin
            busy_err_r <= drop_s;
            if (load_s) begin
                cnt_r  <= load_val_s;
                busy_r <= 1'b1;
            end else if (busy_r) begin
                cnt_r  <= cnt_r - CNT_W'(1);
                busy_r <= (cnt_r != CNT_W'(1));
            end
        end
    end

    // Read data selection, high nibble first in 4-bit operation.
    always_comb begin
        rd_word_s = rs_s ? ddram_r[ddram_idx(ac_r)] : {busy_r, ac_r};
        if (nib_mode_s) begin
            rd_byte_s = phase_hi_r ? {rd_word_s[7:4], 4'h0} : {rd_word_s[3:0], 4'h0};
        end else begin
            rd_byte_s = rd_word_s;
        end
    end

    // Read bus driver, refreshed every cycle while the read strobe is active.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_r <= 8'h00;
            oe_r  <= 1'b0;
        end else begin
            oe_r <= rw_s & en_s;
            if (rw_s && en_s) out_r <= rd_byte_s;
        end
    end

    assign lcd_data_out = out_r;
    assign lcd_data_oe  = oe_r;
    assign disp_on      = disp_r;
    assign cursor_on    = cur_r;
    assign blink_on     = blink_r;
    assign busy         = busy_r;
    assign busy_err     = busy_err_r;
    assign dbg_char     = addr_valid(dbg_addr) ? ddram_r[ddram_idx(dbg_addr)] : 8'h20;

endmodule

// File: tb/tb_lcd_hd44780_resp.sv
// Self-checking bench for lcd_hd44780_resp: directed steps plus randomized operations
// compared against an address-level behavioural model of the LCD module.
module tb_lcd_hd44780_resp;
    localparam int BUSY  = 37;
    localparam int CLEAR = 1520;

    logic       clk = 1'b0, rstn = 1'b0;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
    logic [7:0] lcd_data_in = 8'h00;
    logic [7:0] lcd_data_out, dbg_char;
    logic       lcd_data_oe, disp_on, cursor_on, blink_on, busy, busy_err;
    logic [6:0] dbg_addr = 7'h00;

    int checks = 0, passed = 0;
    int busy_cnt = 0, err_cnt = 0;

    logic [7:0] m_mem [0:127];
    logic [6:0] m_ac;
    logic       m_id, m_d, m_c, m_b;

    lcd_hd44780_resp #(.BUSY_CYC(BUSY), .CLEAR_CYC(CLEAR), .SYNC_STAGES(2)) dut (
        .clk(clk), .rstn(rstn), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on), .busy(busy),
        .busy_err(busy_err), .dbg_addr(dbg_addr), .dbg_char(dbg_char)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
        if (busy_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic m_valid(input logic [6:0] a);
        return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
    endfunction

    function automatic logic [6:0] m_next(input logic [6:0] a, input logic inc);
        if (inc) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
        else     return (a == 7'h40) ? 7'h27 : (a == 7'h00) ? 7'h67 : a - 7'd1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
        m_ac = 7'h00; m_id = 1'b1; m_d = 1'b0; m_c = 1'b0; m_b = 1'b0;
    endtask

    task automatic clr_cnt();
        @(posedge clk);
        busy_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_en = 1'b1;
        repeat (3) @(negedge clk);
        lcd_en = 1'b0;
    endtask

    task automatic settle();
        int idle = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (busy === 1'b1) idle = 0;
            else idle++;
            if (idle >= 8) break;
        end
    endtask

    task automatic data_wr(input logic [7:0] d);
        clr_cnt();
        strobe(1'b1, 1'b0, d);
        settle();
        m_mem[m_ac] = d;
        m_ac = m_next(m_ac, m_id);
        chk("data_busy_cycles", busy_cnt, BUSY);
    endtask

    task automatic instr(input logic [7:0] d);
        int exp_busy;
        clr_cnt();
        strobe(1'b0, 1'b0, d);
        settle();
        exp_busy = BUSY;
        casez (d)
            8'b1???????: if (m_valid(d[6:0])) m_ac = d[6:0];
            8'b01??????: exp_busy = BUSY;
            8'b001?????: exp_busy = BUSY;
            8'b0001????: if (!d[3]) m_ac = m_next(m_ac, d[2]);
            8'b00001???: begin m_d = d[2]; m_c = d[1]; m_b = d[0]; end
            8'b000001??: m_id = d[1];
            8'b0000001?: begin m_ac = 7'h00; exp_busy = CLEAR; end
            8'b00000001: begin
                for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
                m_ac = 7'h00; m_id = 1'b1; exp_busy = CLEAR;
            end
            default: exp_busy = 0;
        endcase
        chk($sformatf("instr_%02h_busy_cycles", d), busy_cnt, exp_busy);
    endtask

    task automatic rd(input logic rs, output logic [7:0] v);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = 1'b1; lcd_data_in = 8'($urandom); lcd_en = 1'b1;
        repeat (4) @(negedge clk);
        v = lcd_data_out;
        chk("read_oe_high", lcd_data_oe, 1'b1);
        lcd_en = 1'b0;
        repeat (5) @(negedge clk);
        lcd_rw = 1'b0;
        chk("read_oe_low", lcd_data_oe, 1'b0);
    endtask

    task automatic check_ac(input string tag);
        logic [7:0] v;
        rd(1'b0, v);
        chk(tag, v, {1'b0, m_ac});
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < 128; a++) begin
            dbg_addr = 7'(a);
            #1;
            chk($sformatf("%s_%02h", tag, a), dbg_char, m_mem[a]);
        end
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_disp"}, disp_on, m_d);
        chk({tag, "_cursor"}, cursor_on, m_c);
        chk({tag, "_blink"}, blink_on, m_b);
    endtask

    initial begin
        logic [7:0] v;
        int op, r;
        m_reset();
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_busy_err", busy_err, 1'b0);
        chk("rst_oe", lcd_data_oe, 1'b0);
        chk("rst_out", lcd_data_out, 8'h00);
        check_flags("rst");
        dbg_addr = 7'h10; #1;
        chk("rst_ddram", dbg_char, 8'h20);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check_ac("rst_ac");

        // initialisation sequence
        instr(8'h38);
        instr(8'h0C);
        instr(8'h06);
        check_flags("init");

        // two characters then busy/AC read
        data_wr(8'h48);
        data_wr(8'h69);
        dbg_addr = 7'h00; #1; chk("char_H", dbg_char, 8'h48);
        dbg_addr = 7'h01; #1; chk("char_i", dbg_char, 8'h69);
        check_ac("ac_after_hi");

        // line-end wrap, both lines
        instr(8'hA7);
        check_ac("ac_set_27");
        data_wr(8'h41);
        dbg_addr = 7'h27; #1; chk("char_27", dbg_char, 8'h41);
        check_ac("ac_wrap_40");
        instr(8'hE7);
        data_wr(8'h42);
        check_ac("ac_wrap_00");
        instr(8'h00);
        instr(8'h02);
        check_ac("ac_home");

        // randomized operations against the model
        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: data_wr(8'($urandom_range(32, 126)));
                1: begin
                    r = $urandom_range(0, 79);
                    instr({1'b1, (r < 40) ? 7'(r) : 7'(r - 40 + 64)});
                end
                2: instr({6'b000001, 1'($urandom_range(0, 1)), 1'b0});
                3: instr({5'b00001, 3'($urandom_range(0, 7))});
                4: instr({5'b00010, 1'($urandom_range(0, 1)), 2'b00});
                default: begin
                    rd(1'b1, v);
                    chk("data_read", v, m_mem[m_ac]);
                    m_ac = m_next(m_ac, m_id);
                end
            endcase
        end
        check_ac("rand_ac");
        check_flags("rand");
        check_mem("rand_mem");

        // write during clear: dropped with one error pulse
        clr_cnt();
        strobe(1'b0, 1'b0, 8'h01);
        repeat (2) @(negedge clk);
        strobe(1'b1, 1'b0, 8'h55);
        settle();
        for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
        m_ac = 7'h00; m_id = 1'b1;
        chk("clear_busy_cycles", busy_cnt, CLEAR);
        chk("busy_err_pulses", err_cnt, 1);
        check_mem("clear_mem");
        check_ac("clear_ac");

        // reset in the middle of a clear countdown
        instr(8'h0F);
        data_wr(8'h77);
        strobe(1'b0, 1'b0, 8'h01);
        repeat (100) @(negedge clk);
        chk("busy_before_rst", busy, 1'b1);
        #2 rstn = 1'b0;
        #1 chk("busy_during_rst", busy, 1'b0);
        m_reset();
        check_flags("midrst");
        @(negedge clk);
        rstn = 1'b1;
        clr_cnt();
        repeat (20) @(negedge clk);
        chk("busy_after_rst", busy_cnt, 0);
        check_ac("midrst_ac");
        check_mem("midrst_mem");

`ifdef LCD_4BIT_EN
        // switch to a 4-bit bus and write one character as two nibbles
        instr(8'h28);
        clr_cnt();
        strobe(1'b1, 1'b0, 8'h40);
        settle();
        chk("nib1_busy_cycles", busy_cnt, 0);
        clr_cnt();
        strobe(1'b1, 1'b0, 8'h80);
        settle();
        chk("nib2_busy_cycles", busy_cnt, BUSY);
        dbg_addr = 7'h00; #1;
        chk("nib_char", dbg_char, 8'h48);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
